// File: rtl/vend_pkg.sv
// Shared definitions for the vending credit controller.
// Holds coin codes, coin values, the price table, the FSM state type
// and lookup helpers for coin value and drink price.
package vend_pkg;

    // Coin codes as seen on the coin_val input
    localparam logic [1:0] COIN_1   = 2'd0;
    localparam logic [1:0] COIN_5   = 2'd1;
    localparam logic [1:0] COIN_10  = 2'd2;
    localparam logic [1:0] COIN_BAD = 2'd3;

    // Coin values in credit units
    localparam int unsigned VAL_1  = 1;
    localparam int unsigned VAL_5  = 5;
    localparam int unsigned VAL_10 = 10;

    // Drink prices in credit units
    localparam int unsigned PRICE_1 = 10;
    localparam int unsigned PRICE_2 = 15;
    localparam int unsigned PRICE_3 = 20;
    localparam int unsigned PRICE_4 = 25;
    localparam int unsigned PRICE_5 = 30;

    typedef enum logic [1:0] {
        StIdle,
        StVend,
        StChange
    } state_e;

    // Value of a coin code; a slug is worth nothing
    function automatic int unsigned coin_value(input logic [1:0] code);
        int unsigned v;
        v = 0;
        unique case (code)
            COIN_1:   v = VAL_1;
            COIN_5:   v = VAL_5;
            COIN_10:  v = VAL_10;
            default:  v = 0;
        endcase
        return v;
    endfunction

    // Price of a drink choice; 0 marks an invalid choice
    function automatic int unsigned price_of(input logic [3:0] choice);
        int unsigned p;
        p = 0;
        case (choice)
            4'd1:    p = PRICE_1;
            4'd2:    p = PRICE_2;
            4'd3:    p = PRICE_3;
            4'd4:    p = PRICE_4;
            4'd5:    p = PRICE_5;
            default: p = 0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/vend_price_lut.sv
// Combinational price lookup for the vending credit controller.
// Ports:
//   i_choice  requested drink code
//   o_price   price in credit units (0 when the choice is invalid)
//   o_valid   high when the choice names a real drink
module vend_price_lut
    import vend_pkg::*;
#(
    parameter int unsigned CW = 6
) (
    input  logic [3:0]    i_choice,
    output logic [CW-1:0] o_price,
    output logic          o_valid
);

    always_comb begin
        o_price = CW'(price_of(i_choice));
        o_valid = (price_of(i_choice) != 0);
    end

endmodule

// File: rtl/vend_credit_ctrl.sv
// Vending credit controller: accumulates coin credit, approves or denies
// purchases against the price table, and hands change/refunds to the coin
// return mechanism over a valid/ack handshake.
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_coin_valid, i_coin_val  coin strobe and coin code
//   i_choice, i_buy, i_cancel drink request, purchase and refund strobes
//   i_change_ack              return mechanism took o_change_amt
//   o_credit                  current credit
//   o_paid, o_drink_sel       approval pulse and latched drink code
//   o_deny, o_coin_reject     denial and coin-return pulses
//   o_change_valid/_amt       change handshake towards coin return
module vend_credit_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned MAX_CREDIT = 50,
    parameter int unsigned CW         = 6
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_coin_valid,
    input  logic [1:0]    i_coin_val,
    input  logic [3:0]    i_choice,
    input  logic          i_buy,
    input  logic          i_cancel,
    input  logic          i_change_ack,
    output logic [CW-1:0] o_credit,
    output logic          o_paid,
    output logic [3:0]    o_drink_sel,
    output logic          o_deny,
    output logic          o_coin_reject,
    output logic          o_change_valid,
    output logic [CW-1:0] o_change_amt
);

    // Coin acceptance is judged one bit wider so the sum cannot wrap
    localparam int unsigned CW1 = CW + 1;

    state_e        r_state;
    logic [CW-1:0] r_credit;
    logic [CW-1:0] r_change_amt;
    logic [3:0]    r_drink_sel;
    logic          r_paid;
    logic          r_deny;
    logic          r_coin_reject;
    logic          r_change_valid;

    logic [CW-1:0] w_price;
    logic          w_choice_ok;
    logic [CW:0]   w_credit_sum;
    logic          w_coin_fits;
    logic          w_can_buy;

    vend_price_lut #(
        .CW (CW)
    ) u_price_lut (
        .i_choice (i_choice),
        .o_price  (w_price),
        .o_valid  (w_choice_ok)
    );

    always_comb begin
        w_credit_sum = {1'b0, r_credit} + CW1'(coin_value(i_coin_val));
        w_coin_fits  = (i_coin_val != COIN_BAD) && (w_credit_sum <= CW1'(MAX_CREDIT));
        w_can_buy    = w_choice_ok && (r_credit >= w_price);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= StIdle;
            r_credit       <= '0;
            r_change_amt   <= '0;
            r_drink_sel    <= 4'd0;
            r_paid         <= 1'b0;
            r_deny         <= 1'b0;
            r_coin_reject  <= 1'b0;
            r_change_valid <= 1'b0;
        end else begin
            r_paid        <= 1'b0;
            r_deny        <= 1'b0;
            r_coin_reject <= 1'b0;

            unique case (r_state)
                StIdle: begin
                    if (i_cancel) begin
                        // Cancel beats buy; a zero-credit cancel does nothing
                        if (r_credit != '0) begin
                            r_change_amt   <= r_credit;
                            r_credit       <= '0;
                            r_change_valid <= 1'b1;
                            r_state        <= StChange;
                        end
                        if (i_coin_valid) r_coin_reject <= 1'b1;
                    end else if (i_buy) begin
                        if (w_can_buy) begin
                            r_paid       <= 1'b1;
                            r_drink_sel  <= i_choice;
                            r_change_amt <= r_credit - w_price;
                            r_credit     <= '0;
                            r_state      <= StVend;
                        end else begin
                            r_deny <= 1'b1;
                        end
                        if (i_coin_valid) r_coin_reject <= 1'b1;
                    end else if (i_coin_valid) begin
                        if (w_coin_fits) r_credit <= w_credit_sum[CW-1:0];
                        else             r_coin_reject <= 1'b1;
                    end
                end

                StVend: begin
                    if (i_coin_valid) r_coin_reject <= 1'b1;
                    if (r_change_amt != '0) begin
                        r_change_valid <= 1'b1;
                        r_state        <= StChange;
                    end else begin
                        r_state <= StIdle;
                    end
                end

                StChange: begin
                    if (i_coin_valid) r_coin_reject <= 1'b1;
                    if (i_change_ack) begin
                        r_change_valid <= 1'b0;
                        r_change_amt   <= '0;
                        r_state        <= StIdle;
                    end
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_credit       = r_credit;
    assign o_paid         = r_paid;
    assign o_drink_sel    = r_drink_sel;
    assign o_deny         = r_deny;
    assign o_coin_reject  = r_coin_reject;
    assign o_change_valid = r_change_valid;
    assign o_change_amt   = r_change_amt;

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Self-checking bench for vend_credit_ctrl: directed scenarios followed by
// random traffic, every output compared each cycle against a transaction
// level model of the vending rules.
module tb_vend_credit_ctrl;

    localparam int unsigned CW = 6;
    localparam int MAXC = 50;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          coin_valid = 1'b0;
    logic [1:0]    coin_val = 2'd0;
    logic [3:0]    choice = 4'd0;
    logic          buy = 1'b0;
    logic          cancel = 1'b0;
    logic          change_ack = 1'b0;
    logic [CW-1:0] credit;
    logic          paid;
    logic [3:0]    drink_sel;
    logic          deny;
    logic          coin_reject;
    logic          change_valid;
    logic [CW-1:0] change_amt;

    vend_credit_ctrl #(
        .MAX_CREDIT (MAXC),
        .CW         (CW)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_coin_valid   (coin_valid),
        .i_coin_val     (coin_val),
        .i_choice       (choice),
        .i_buy          (buy),
        .i_cancel       (cancel),
        .i_change_ack   (change_ack),
        .o_credit       (credit),
        .o_paid         (paid),
        .o_drink_sel    (drink_sel),
        .o_deny         (deny),
        .o_coin_reject  (coin_reject),
        .o_change_valid (change_valid),
        .o_change_amt   (change_amt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: machine "phase" is one of ready / dispensing / returning
    localparam int PH_READY = 0;
    localparam int PH_DISP  = 1;
    localparam int PH_RET   = 2;
    int price_tab [16] = '{0, 10, 15, 20, 25, 30, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int value_tab [4]  = '{1, 5, 10, 0};
    int m_phase  = PH_READY;
    int m_credit = 0;
    int m_change = 0;
    int m_sel    = 0;
    int e_paid   = 0;
    int e_deny   = 0;
    int e_rej    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, obs, exp);
    endtask

    task automatic model_step();
        int p;
        e_paid = 0;
        e_deny = 0;
        e_rej  = 0;
        if (rst) begin
            m_phase  = PH_READY;
            m_credit = 0;
            m_change = 0;
            m_sel    = 0;
        end else if (m_phase == PH_READY) begin
            if (cancel) begin
                if (m_credit > 0) begin
                    m_change = m_credit;
                    m_credit = 0;
                    m_phase  = PH_RET;
                end
                if (coin_valid) e_rej = 1;
            end else if (buy) begin
                p = price_tab[choice];
                if (p != 0 && m_credit >= p) begin
                    e_paid   = 1;
                    m_sel    = int'(choice);
                    m_change = m_credit - p;
                    m_credit = 0;
                    m_phase  = PH_DISP;
                end else begin
                    e_deny = 1;
                end
                if (coin_valid) e_rej = 1;
            end else if (coin_valid) begin
                if (coin_val == 2'd3 || m_credit + value_tab[coin_val] > MAXC) e_rej = 1;
                else m_credit = m_credit + value_tab[coin_val];
            end
        end else if (m_phase == PH_DISP) begin
            if (coin_valid) e_rej = 1;
            m_phase = (m_change > 0) ? PH_RET : PH_READY;
        end else begin
            if (coin_valid) e_rej = 1;
            if (change_ack) begin
                m_change = 0;
                m_phase  = PH_READY;
            end
        end
    endtask

    task automatic check_all();
        check("credit",       32'(credit),       32'(m_credit));
        check("paid",         32'(paid),         32'(e_paid));
        check("drink_sel",    32'(drink_sel),    32'(m_sel));
        check("deny",         32'(deny),         32'(e_deny));
        check("coin_reject",  32'(coin_reject),  32'(e_rej));
        check("change_valid", 32'(change_valid), 32'(m_phase == PH_RET));
        check("change_amt",   32'(change_amt),   32'(m_change));
    endtask

    // Apply one cycle of inputs, clock it, then compare against the model
    task automatic step(input logic r, input logic cv, input logic [1:0] cval,
                        input logic [3:0] ch, input logic b, input logic c, input logic a);
        rst        = r;
        coin_valid = cv;
        coin_val   = cval;
        choice     = ch;
        buy        = b;
        cancel     = c;
        change_ack = a;
        @(posedge clk);
        #1;
        model_step();
        check_all();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic coin(input logic [1:0] code);
        step(1'b0, 1'b1, code, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic buy_it(input logic [3:0] ch);
        step(1'b0, 1'b0, 2'd0, ch, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic ack();
        step(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        // Reset
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        check("rst_credit", 32'(credit), 32'd0);
        check("rst_change_valid", 32'(change_valid), 32'd0);
        idle();

        // 10 + 5, buy choice 2: exact price, no change
        coin(2'd2);
        coin(2'd1);
        check("s1_credit15", 32'(credit), 32'd15);
        buy_it(4'd2);
        check("s1_paid", 32'(paid), 32'd1);
        check("s1_sel", 32'(drink_sel), 32'd2);
        idle();
        check("s1_paid_once", 32'(paid), 32'd0);
        check("s1_no_change", 32'(change_valid), 32'd0);
        idle();

        // 31 units, buy choice 3: change 11 held until ack
        coin(2'd2);
        coin(2'd2);
        coin(2'd2);
        coin(2'd0);
        buy_it(4'd3);
        idle();
        check("s2_cv", 32'(change_valid), 32'd1);
        check("s2_amt", 32'(change_amt), 32'd11);
        for (int i = 0; i < 4; i++) idle();
        check("s2_amt_held", 32'(change_amt), 32'd11);
        ack();
        check("s2_cv_drop", 32'(change_valid), 32'd0);
        idle();

        // Denials, then refund
        coin(2'd2);
        buy_it(4'd5);
        check("s3_deny_price", 32'(deny), 32'd1);
        check("s3_credit_kept", 32'(credit), 32'd10);
        buy_it(4'd7);
        check("s3_deny_choice", 32'(deny), 32'd1);
        step(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        check("s3_refund", 32'(change_amt), 32'd10);
        ack();
        idle();

        // Credit ceiling
        for (int i = 0; i < 4; i++) coin(2'd2);
        coin(2'd1);
        coin(2'd2);
        check("s4_overflow_rej", 32'(coin_reject), 32'd1);
        check("s4_credit45", 32'(credit), 32'd45);
        coin(2'd3);
        check("s4_slug_rej", 32'(coin_reject), 32'd1);
        coin(2'd1);
        check("s4_credit50", 32'(credit), 32'd50);
        step(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        ack();

        // buy + cancel + coin together: cancel wins, coin rejected
        coin(2'd2);
        coin(2'd2);
        step(1'b0, 1'b1, 2'd1, 4'd1, 1'b1, 1'b1, 1'b0);
        check("s5_refund20", 32'(change_amt), 32'd20);
        check("s5_rej", 32'(coin_reject), 32'd1);
        check("s5_no_paid", 32'(paid), 32'd0);
        check("s5_no_deny", 32'(deny), 32'd0);
        ack();

        // Reset in the first change cycle
        coin(2'd2);
        coin(2'd2);
        coin(2'd2);
        buy_it(4'd1);
        idle();
        check("s6_in_change", 32'(change_valid), 32'd1);
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        check("s6_rst_cv", 32'(change_valid), 32'd0);
        check("s6_rst_amt", 32'(change_amt), 32'd0);
        check("s6_rst_sel", 32'(drink_sel), 32'd0);
        coin(2'd1);
        check("s6_coin_after", 32'(credit), 32'd5);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 1) == 1),
                 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 7)),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 2) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
